// File: rtl/input_debounce_pkg.sv
// Shared types and defaults for the pin debouncer.
// FSM encoding, default counter width and idle level.
package input_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_t;

  localparam int   DEF_CNT_W = 16;
  localparam logic DEF_IDLE  = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// N-flop synchroniser for asynchronous pins.
// Async reset loads every stage with RST_VAL.
module sync_ff #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= {N{RST_VAL}};
    else     r <= {r[N-2:0], d};
  end

  assign q = r[N-1];

endmodule

// File: rtl/input_debounce.sv
// Pin conditioner: synchronise, debounce, emit rise/fall pulses.
// Feeds the single-bit x input of the inverter stage.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RESET_VAL   = DEF_IDLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic [CNT_W-1:0] thresh,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy
);

  logic             s;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   thr_eff;
  logic [CNT_W-1:0] cnt_sat;
  logic             flip;

  sync_ff #(
    .N       (SYNC_STAGES),
    .RST_VAL (RESET_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  // STABLE always counts from zero, whatever cnt holds.
  always_comb begin
    cnt_inc = '0;
    thr_eff = '0;
    cnt_sat = '0;
    flip    = 1'b0;
    if (state == ST_COUNT) cnt_inc = {1'b0, cnt} + 1'b1;
    else                   cnt_inc = {{CNT_W{1'b0}}, 1'b1};
    if (thresh == '0) thr_eff = {{CNT_W{1'b0}}, 1'b1};
    else              thr_eff = {1'b0, thresh};
    cnt_sat = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
    flip    = (cnt_inc >= thr_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      dout  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!en || s == dout) begin
        state <= ST_STABLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else if (flip) begin
        state <= ST_STABLE;
        cnt   <= '0;
        busy  <= 1'b0;
        dout  <= s;
        rise  <= s;
        fall  <= ~s;
      end else begin
        state <= ST_COUNT;
        cnt   <= cnt_sat;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with default parameters.
// Edge numbers count rising edges after the stimulus change.
module tb_input_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        en;
  logic [15:0] thresh;
  logic        dout;
  logic        rise;
  logic        fall;
  logic        busy;

  int total = 0;
  int bad   = 0;

  input_debounce #(
    .SYNC_STAGES (2),
    .CNT_W       (16),
    .RESET_VAL   (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .en     (en),
    .thresh (thresh),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int flip_at;
    int fall_cnt;
    int fall_at;
    rst = 1'b1; din = 1'b0; en = 1'b1; thresh = 16'd4;
    #2;
    total++;
    if (dout !== 1'b1 || rise !== 1'b0 || fall !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: got dout=%b rise=%b fall=%b busy=%b want 1 0 0 0",
               dout, rise, fall, busy);
    end
    tick; tick;
    total++;
    if (dout !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold: got dout=%b want 1", dout);
    end
    rst = 1'b0;
    flip_at = 0; fall_cnt = 0; fall_at = 0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (dout === 1'b0 && flip_at == 0) flip_at = k;
      if (fall === 1'b1) begin
        fall_cnt++;
        fall_at = k;
      end
    end
    total++;
    if (flip_at != 6) begin
      bad++;
      $display("FAIL reset_release_flip: got edge %0d want 6", flip_at);
    end
    total++;
    if (fall_cnt != 1 || fall_at != 6) begin
      bad++;
      $display("FAIL reset_release_fall: got %0d pulses at %0d want 1 at 6",
               fall_cnt, fall_at);
    end
  endtask

  task automatic test_bounce;
    int changes;
    int pulses;
    int busy_seen;
    thresh = 16'd4;
    changes = 0; pulses = 0; busy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      din = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
      tick;
      if (dout !== 1'b0) changes++;
      if (rise === 1'b1 || fall === 1'b1) pulses++;
      if (busy === 1'b1) busy_seen++;
    end
    din = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (dout !== 1'b0) changes++;
      if (rise === 1'b1 || fall === 1'b1) pulses++;
    end
    total++;
    if (changes != 0) begin
      bad++;
      $display("FAIL bounce_dout: got %0d cycles with dout!=0 want 0", changes);
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL bounce_pulse: got %0d pulses want 0", pulses);
    end
    total++;
    if (busy_seen == 0) begin
      bad++;
      $display("FAIL bounce_busy: got busy high %0d cycles want >0", busy_seen);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bounce_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_zero_thresh;
    int e1;
    int e0;
    thresh = 16'd1; din = 1'b1; e1 = 0;
    for (int k = 1; k <= 10 && e1 == 0; k++) begin
      tick;
      if (dout === 1'b1) e1 = k;
    end
    total++;
    if (e1 != 3) begin
      bad++;
      $display("FAIL thresh1_rise: got edge %0d want 3", e1);
    end
    tick; tick;
    thresh = 16'd0; din = 1'b0; e0 = 0;
    for (int k = 1; k <= 10 && e0 == 0; k++) begin
      tick;
      if (dout === 1'b0) begin
        e0 = k;
        total++;
        if (fall !== 1'b1) begin
          bad++;
          $display("FAIL thresh0_fall_pulse: got %b want 1", fall);
        end
      end
    end
    total++;
    if (e0 != 3) begin
      bad++;
      $display("FAIL thresh0_fall: got edge %0d want 3", e0);
    end
    tick; tick;
  endtask

  task automatic test_enable;
    int errs;
    int e;
    en = 1'b0; din = 1'b1; errs = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (dout !== 1'b0 || busy !== 1'b0 || rise !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL en_hold: got %0d bad cycles want 0", errs);
    end
    en = 1'b1; thresh = 16'd5; e = 0;
    for (int k = 1; k <= 20 && e == 0; k++) begin
      tick;
      if (dout === 1'b1) e = k;
    end
    total++;
    if (e != 5) begin
      bad++;
      $display("FAIL en_release_flip: got edge %0d want 5", e);
    end
    tick; tick;
    thresh = 16'd3; din = 1'b0;
    tick; tick; tick; tick;
    en = 1'b0;
    tick;
    total++;
    if (dout !== 1'b1 || fall !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL en_wins: got dout=%b fall=%b busy=%b want 1 0 0",
               dout, fall, busy);
    end
    en = 1'b1; e = 0;
    for (int k = 1; k <= 10 && e == 0; k++) begin
      tick;
      if (dout === 1'b0) e = k;
    end
    total++;
    if (e != 3) begin
      bad++;
      $display("FAIL en_restart: got edge %0d want 3", e);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int e;
    int pulses;
    thresh = 16'd8; din = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    total++;
    if (busy !== 1'b1 || dout !== 1'b0) begin
      bad++;
      $display("FAIL mid_counting: got busy=%b dout=%b want 1 0", busy, dout);
    end
    rst = 1'b1;
    #1;
    total++;
    if (dout !== 1'b1 || busy !== 1'b0 || rise !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: got dout=%b busy=%b rise=%b want 1 0 0",
               dout, busy, rise);
    end
    din = 1'b0; pulses = 0;
    tick;
    if (rise === 1'b1 || fall === 1'b1) pulses++;
    tick;
    if (rise === 1'b1 || fall === 1'b1) pulses++;
    rst = 1'b0; e = 0;
    for (int k = 1; k <= 20 && e == 0; k++) begin
      tick;
      if (dout === 1'b0) e = k;
      else if (rise === 1'b1 || fall === 1'b1) pulses++;
    end
    total++;
    if (e != 10) begin
      bad++;
      $display("FAIL mid_restart: got edge %0d want 10", e);
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL mid_pulse: got %0d stray pulses want 0", pulses);
    end
    tick;
  endtask

  task automatic test_thresh_change;
    thresh = 16'd100; din = 1'b1;
    for (int k = 0; k < 22; k++) tick;
    total++;
    if (dout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL thr_before: got dout=%b busy=%b want 0 1", dout, busy);
    end
    thresh = 16'd5;
    tick;
    total++;
    if (dout !== 1'b1 || rise !== 1'b1 || fall !== 1'b0) begin
      bad++;
      $display("FAIL thr_flip: got dout=%b rise=%b fall=%b want 1 1 0",
               dout, rise, fall);
    end
    tick;
    total++;
    if (rise !== 1'b0 || dout !== 1'b1) begin
      bad++;
      $display("FAIL thr_pulse_width: got rise=%b dout=%b want 0 1", rise, dout);
    end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_zero_thresh;
    test_enable;
    test_reset_mid;
    test_thresh_change;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
